// File: rtl/pipeline_pkg.sv
// Shared width defaults and result-sizing helpers for the A*B+C pipeline.
// PIPELINE_SAT_EN selects saturating instead of truncating result sizing.
package pipeline_pkg;

    localparam int unsigned INP_W_DEF = 2;
    localparam int unsigned OUT_W_DEF = 4;

    // Common carrier width used to hand the sum to the sizing helper.
    localparam int unsigned RESIZE_W = 64;

    function automatic int unsigned prod_w(input int unsigned inp_w);
        return 2 * inp_w;
    endfunction

    function automatic int unsigned sum_w(input int unsigned inp_w);
        return prod_w(inp_w) + 1;
    endfunction

    function automatic logic [RESIZE_W-1:0] out_mask(input int unsigned out_w);
        logic [RESIZE_W-1:0] mask;
        if (out_w >= RESIZE_W) begin
            mask = '1;
        end else begin
            mask = (RESIZE_W'(1) << out_w) - RESIZE_W'(1);
        end
        return mask;
    endfunction

    function automatic logic [RESIZE_W-1:0] resize_sum(input logic [RESIZE_W-1:0] sum,
                                                       input int unsigned out_w);
        logic [RESIZE_W-1:0] mask;
        logic [RESIZE_W-1:0] res;
        mask = out_mask(out_w);
`ifdef PIPELINE_SAT_EN
        // Any bit above the output range means the value does not fit: clamp.
        if ((sum & ~mask) != '0) begin
            res = mask;
        end else begin
            res = sum;
        end
`else
        res = sum & mask;
`endif
        return res;
    endfunction

endpackage

// File: rtl/pipeline_stage_reg.sv
// Generic pipeline register: synchronous active-high clear, holds while en is low.
module pipeline_stage_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline.sv
// Three-stage registered X = A*B + C with a global stall; reset beats stall.
// Build with PIPELINE_SAT_EN defined to saturate X instead of truncating it.
module pipeline
    import pipeline_pkg::*;
#(
    parameter int unsigned INP_WIDTH = INP_W_DEF,
    parameter int unsigned OUT_WIDTH = OUT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [INP_WIDTH-1:0] A,
    input  logic [INP_WIDTH-1:0] B,
    input  logic [INP_WIDTH-1:0] C,
    output logic [OUT_WIDTH-1:0] X
);

    localparam int unsigned PROD_W = prod_w(INP_WIDTH);
    localparam int unsigned SUM_W  = sum_w(INP_WIDTH);

    logic                 en;
    logic [INP_WIDTH-1:0] a1, b1, c1;
    logic [PROD_W-1:0]    prod;
    logic [PROD_W-1:0]    p2;
    logic [INP_WIDTH-1:0] c2;
    logic [SUM_W-1:0]     sum;
    logic [OUT_WIDTH-1:0] x_next;

    always_comb begin
        en = !stall;
    end

    // Stage 1: operand capture
    pipeline_stage_reg #(.WIDTH(INP_WIDTH)) u_a1 (
        .clk (clk), .rst (rst), .en (en), .d (A), .q (a1)
    );
    pipeline_stage_reg #(.WIDTH(INP_WIDTH)) u_b1 (
        .clk (clk), .rst (rst), .en (en), .d (B), .q (b1)
    );
    pipeline_stage_reg #(.WIDTH(INP_WIDTH)) u_c1 (
        .clk (clk), .rst (rst), .en (en), .d (C), .q (c1)
    );

    // Stage 2: full-width product, addend carried alongside
    always_comb begin
        prod = PROD_W'(a1) * PROD_W'(b1);
    end

    pipeline_stage_reg #(.WIDTH(PROD_W)) u_p2 (
        .clk (clk), .rst (rst), .en (en), .d (prod), .q (p2)
    );
    pipeline_stage_reg #(.WIDTH(INP_WIDTH)) u_c2 (
        .clk (clk), .rst (rst), .en (en), .d (c1), .q (c2)
    );

    // Stage 3: lossless sum, then sized to the output width
    always_comb begin
        sum    = SUM_W'(p2) + SUM_W'(c2);
        x_next = OUT_WIDTH'(resize_sum(RESIZE_W'(sum), OUT_WIDTH));
    end

    pipeline_stage_reg #(.WIDTH(OUT_WIDTH)) u_x (
        .clk (clk), .rst (rst), .en (en), .d (x_next), .q (X)
    );

endmodule

// File: tb/tb_pipeline.sv
// Scoreboard bench for pipeline: a 4-bit-output and a 3-bit-output instance share stimulus.
module tb_pipeline;

    localparam int unsigned W = 2;

    typedef struct {
        int x4;
        int x3;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         stall = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] C = '0;
    logic [3:0]   x4;
    logic [2:0]   x3;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    bit   done = 1'b0;

    always #5 clk = ~clk;

    pipeline #(.INP_WIDTH(W), .OUT_WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .A     (A),
        .B     (B),
        .C     (C),
        .X     (x4)
    );

    pipeline #(.INP_WIDTH(W), .OUT_WIDTH(3)) dut_n3 (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .A     (A),
        .B     (B),
        .C     (C),
        .X     (x3)
    );

    // Reference: exact a*b+c, then fitted to w bits by clamping or modulo.
    function automatic int fit(input int sum, input int w);
        int max_v;
        max_v = (1 << w) - 1;
`ifdef PIPELINE_SAT_EN
        return (sum > max_v) ? max_v : sum;
`else
        return sum % (1 << w);
`endif
    endfunction

    function automatic exp_t model(input int a, input int b, input int c);
        exp_t e;
        e.x4 = fit(a * b + c, 4);
        e.x3 = fit(a * b + c, 3);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
        end
    endtask

    // Results leave in sampling order, two edges behind; reset refills the gap with zeros.
    task automatic drive(input logic r, input logic s, input int a, input int b, input int c);
        exp_t z;
        @(negedge clk);
        rst   = r;
        stall = s;
        A     = W'(a);
        B     = W'(b);
        C     = W'(c);
        if (r) begin
            z = '{x4: 0, x3: 0};
            sb.delete();
            sb.push_back(z);
            sb.push_back(z);
        end else if (!s) begin
            sb.push_back(model(a, b, c));
        end
    endtask

    // Monitor: one expected result consumed per non-stalled edge; stalls must hold X.
    initial begin : monitor
        logic r, s;
        bit   started;
        exp_t cur;
        exp_t t;
        started = 1'b0;
        cur = '{x4: 0, x3: 0};
        forever begin
            @(posedge clk);
            r = rst;
            s = stall;
            #1;
            if (r) begin
                started = 1'b1;
                cur = '{x4: 0, x3: 0};
            end else if (started && !s) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow at %0t: got empty queue, expected entry",
                             $time);
                end else begin
                    t = sb.pop_front();
                    cur = t;
                end
            end
            if (started && !done) begin
                check("x_out4", 32'(x4), cur.x4);
                check("x_out3", 32'(x3), cur.x3);
            end
        end
    end

    initial begin : stimulus
        // Reset for two edges with nonzero operands, then three idle edges.
        drive(1, 0, 3, 3, 3);
        drive(1, 0, 3, 3, 3);
        repeat (3) drive(0, 0, 0, 0, 0);

        // Single operand set followed by zeros.
        drive(0, 0, 1, 1, 1);
        repeat (4) drive(0, 0, 0, 0, 0);

        // Stall for two edges with different operands presented meanwhile.
        drive(0, 0, 2, 2, 2);
        drive(0, 1, 3, 3, 3);
        drive(0, 1, 1, 3, 1);
        repeat (3) drive(0, 0, 0, 0, 0);

        // Mixed operands after release.
        drive(0, 0, 3, 1, 2);
        repeat (3) drive(0, 0, 0, 0, 0);

        // Back-to-back streaming.
        drive(0, 0, 3, 3, 3);
        drive(0, 0, 2, 3, 1);
        drive(0, 0, 0, 0, 3);
        repeat (3) drive(0, 0, 0, 0, 0);

        // Reset with two results in flight.
        drive(0, 0, 3, 3, 3);
        drive(0, 0, 2, 3, 1);
        drive(1, 1, 1, 1, 1);
        repeat (4) drive(0, 0, 0, 0, 0);

        // Randomised traffic with occasional stalls and resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
        end
        repeat (4) drive(0, 0, 0, 0, 0);

        @(negedge clk);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
